// File: rtl/lif_scheduler.sv
// Time-multiplexed leaky integrate-and-fire layer: one shared datapath walks N membrane states per timestep.
// Optional refractory period per neuron is enabled with `define LIF_SCHED_REFRACTORY_EN.
module lif_scheduler #(
    parameter int N_NEURONS = 4,
    parameter int WIDTH     = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start,
    input  logic [2:0]                   beta,
    input  logic [WIDTH-1:0]             threshold,
    output logic [$clog2(N_NEURONS)-1:0] cur_idx,
    input  logic [WIDTH-1:0]             cur_data,
    output logic                         spike_valid,
    output logic [$clog2(N_NEURONS)-1:0] spike_idx,
    input  logic                         spike_ready,
    output logic                         busy,
    output logic                         done,
    input  logic [$clog2(N_NEURONS)-1:0] mem_sel,
    output logic [WIDTH-1:0]             mem_out
);

    localparam int IW = $clog2(N_NEURONS);

    typedef enum logic [1:0] {IDLE, RUN, EMIT, DONE} state_e;

    state_e            fsm_q;
    logic [IW-1:0]     idx_q;
    logic [WIDTH-1:0]  mem_q [N_NEURONS];
    logic              spikeValid_q;
    logic [IW-1:0]     spikeIdx_q;
    logic              busy_q;
    logic              done_q;
    logic [WIDTH-1:0]  memOut_q;
`ifdef LIF_SCHED_REFRACTORY_EN
    logic [N_NEURONS-1:0] refr_q;
`endif

    logic [WIDTH-1:0]  curState;
    logic [WIDTH-1:0]  leak;
    logic [WIDTH:0]    sumWide;
    logic [WIDTH-1:0]  mem_d;
    logic              fire;
    logic              skip;
    logic              lastIdx;
    state_e            advFsm_d;
    logic [IW-1:0]     advIdx_d;

    // Shared datapath: the extra sum bit catches overflow so it can saturate instead of wrapping.
    always_comb begin
        curState = mem_q[idx_q];
        leak     = (beta == 3'd0) ? '0 : (curState >> beta);
        sumWide  = {1'b0, curState} - {1'b0, leak} + {1'b0, cur_data};
        mem_d    = sumWide[WIDTH] ? '1 : sumWide[WIDTH-1:0];
        fire     = (mem_d >= threshold);
        lastIdx  = (idx_q == IW'(N_NEURONS - 1));
        advFsm_d = lastIdx ? DONE : RUN;
        advIdx_d = lastIdx ? idx_q : idx_q + 1'b1;
`ifdef LIF_SCHED_REFRACTORY_EN
        skip     = refr_q[idx_q];
`else
        skip     = 1'b0;
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fsm_q        <= IDLE;
            idx_q        <= '0;
            spikeValid_q <= 1'b0;
            spikeIdx_q   <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            memOut_q     <= '0;
            for (int n = 0; n < N_NEURONS; n++) begin
                mem_q[n] <= '0;
            end
`ifdef LIF_SCHED_REFRACTORY_EN
            refr_q       <= '0;
`endif
        end else begin
            memOut_q <= mem_q[mem_sel];
            done_q   <= 1'b0;
            case (fsm_q)
                IDLE: begin
                    if (start) begin
                        idx_q  <= '0;
                        fsm_q  <= RUN;
                        busy_q <= 1'b1;
                    end
                end
                RUN: begin
                    // A refractory neuron still consumes its slot but keeps its zeroed state.
                    if (skip) begin
`ifdef LIF_SCHED_REFRACTORY_EN
                        refr_q[idx_q] <= 1'b0;
`endif
                        fsm_q  <= advFsm_d;
                        idx_q  <= advIdx_d;
                        busy_q <= !lastIdx;
                        done_q <= lastIdx;
                    end else if (fire) begin
                        mem_q[idx_q] <= '0;
                        spikeValid_q <= 1'b1;
                        spikeIdx_q   <= idx_q;
                        fsm_q        <= EMIT;
`ifdef LIF_SCHED_REFRACTORY_EN
                        refr_q[idx_q] <= 1'b1;
`endif
                    end else begin
                        mem_q[idx_q] <= mem_d;
                        fsm_q        <= advFsm_d;
                        idx_q        <= advIdx_d;
                        busy_q       <= !lastIdx;
                        done_q       <= lastIdx;
                    end
                end
                EMIT: begin
                    if (spike_ready) begin
                        spikeValid_q <= 1'b0;
                        fsm_q        <= advFsm_d;
                        idx_q        <= advIdx_d;
                        busy_q       <= !lastIdx;
                        done_q       <= lastIdx;
                    end
                end
                DONE: begin
                    fsm_q <= IDLE;
                end
                default: begin
                    fsm_q <= IDLE;
                end
            endcase
        end
    end

    assign cur_idx     = idx_q;
    assign spike_valid = spikeValid_q;
    assign spike_idx   = spikeIdx_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign mem_out     = memOut_q;

endmodule

// File: tb/tb_lif_scheduler.sv
// Self-checking bench for lif_scheduler: per-timestep behavioural model plus cycle-by-cycle protocol checks.
// Honours LIF_SCHED_REFRACTORY_EN in the model when the macro is defined.
module tb_lif_scheduler;

    localparam int N  = 4;
    localparam int W  = 8;
    localparam int IW = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [2:0]    beta;
    logic [W-1:0]  threshold;
    logic [IW-1:0] cur_idx;
    logic [W-1:0]  cur_data;
    logic          spike_valid;
    logic [IW-1:0] spike_idx;
    logic          spike_ready;
    logic          busy;
    logic          done;
    logic [IW-1:0] mem_sel;
    logic [W-1:0]  mem_out;

    int vectors = 0;
    int miscompares = 0;

    int modelState [N];
    bit modelRefr  [N];
    int curArr     [N];
    bit fireExp    [N];
    int nextState  [N];
    bit nextRefr   [N];

    int busyCycles;
    int spikes;

    lif_scheduler #(.N_NEURONS(N), .WIDTH(W)) dut (
        .clk(clk), .rst(rst), .start(start), .beta(beta), .threshold(threshold),
        .cur_idx(cur_idx), .cur_data(cur_data), .spike_valid(spike_valid),
        .spike_idx(spike_idx), .spike_ready(spike_ready), .busy(busy), .done(done),
        .mem_sel(mem_sel), .mem_out(mem_out)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input int actual, input int expected);
        vectors++;
        if (actual != expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    // Whole-timestep outcome straight from the leak/integrate/clamp/fire rules.
    task automatic computeModel();
        int leak;
        int s;
        for (int n = 0; n < N; n++) begin
            fireExp[n]  = 1'b0;
            nextRefr[n] = modelRefr[n];
`ifdef LIF_SCHED_REFRACTORY_EN
            if (modelRefr[n]) begin
                nextState[n] = modelState[n];
                nextRefr[n]  = 1'b0;
                continue;
            end
`endif
            leak = (beta == 0) ? 0 : (modelState[n] >> beta);
            s = modelState[n] - leak + curArr[n];
            if (s > (1 << W) - 1) s = (1 << W) - 1;
            if (s >= int'(threshold)) begin
                fireExp[n]   = 1'b1;
                nextState[n] = 0;
                nextRefr[n]  = 1'b1;
            end else begin
                nextState[n] = s;
            end
        end
    endtask

    // readyMode: 0 always ready, 1 random ready, 2 five stalled cycles on the first spike.
    task automatic applyStimulus(input int readyMode);
        int j = 0;
        bit inEmit = 1'b0;
        int stallLeft = (readyMode == 2) ? 5 : 0;
        computeModel();
        busyCycles = 0;
        spikes = 0;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        while (j < N && busyCycles < 200) begin
            @(negedge clk);
            start    = 1'($urandom_range(0, 1));
            cur_data = W'(curArr[j]);
            case (readyMode)
                0: spike_ready = 1'b1;
                1: spike_ready = 1'($urandom_range(0, 1));
                default: begin
                    if (inEmit && stallLeft > 0) begin
                        spike_ready = 1'b0;
                        stallLeft--;
                    end else begin
                        spike_ready = 1'b1;
                    end
                end
            endcase
            checkOutput("busy", int'(busy), 1);
            checkOutput("done_early", int'(done), 0);
            checkOutput("cur_idx", int'(cur_idx), j);
            checkOutput("spike_valid", int'(spike_valid), int'(inEmit));
            if (inEmit) checkOutput("spike_idx", int'(spike_idx), j);
            busyCycles++;
            if (inEmit) begin
                if (spike_ready) begin
                    inEmit = 1'b0;
                    spikes++;
                    j++;
                end
            end else if (fireExp[j]) begin
                inEmit = 1'b1;
            end else begin
                j++;
            end
            @(posedge clk);
        end
        if (j < N) checkOutput("timestep_timeout", busyCycles, -1);
        @(negedge clk);
        start = 1'($urandom_range(0, 1));
        checkOutput("done_pulse", int'(done), 1);
        checkOutput("busy_in_done", int'(busy), 0);
        checkOutput("valid_in_done", int'(spike_valid), 0);
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        checkOutput("done_single", int'(done), 0);
        checkOutput("idle_busy", int'(busy), 0);
        @(posedge clk);
        @(negedge clk);
        checkOutput("idle_busy2", int'(busy), 0);
        checkOutput("idle_done2", int'(done), 0);
        for (int n = 0; n < N; n++) begin
            modelState[n] = nextState[n];
            modelRefr[n]  = nextRefr[n];
        end
    endtask

    task automatic readOne(input int sel, input int expected, input string name);
        @(negedge clk);
        mem_sel = IW'(sel);
        @(posedge clk);
        @(negedge clk);
        checkOutput(name, int'(mem_out), expected);
    endtask

    task automatic readAll();
        for (int s = 0; s < N; s++) readOne(s, modelState[s], "mem_out");
    endtask

    task automatic doReset();
        @(negedge clk);
        rst = 1'b1;
        start = 1'b0;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        checkOutput("rst_busy", int'(busy), 0);
        checkOutput("rst_done", int'(done), 0);
        checkOutput("rst_valid", int'(spike_valid), 0);
        checkOutput("rst_cur_idx", int'(cur_idx), 0);
        checkOutput("rst_spike_idx", int'(spike_idx), 0);
        checkOutput("rst_mem_out", int'(mem_out), 0);
        rst = 1'b0;
        for (int n = 0; n < N; n++) begin
            modelState[n] = 0;
            modelRefr[n]  = 1'b0;
        end
    endtask

    task automatic setAll(input int cur, input int b, input int thr);
        for (int n = 0; n < N; n++) curArr[n] = cur;
        beta = 3'(b);
        threshold = W'(thr);
    endtask

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        rst = 1'b1; start = 1'b0; beta = '0; threshold = '0; cur_data = '0;
        spike_ready = 1'b1; mem_sel = '0;

        // Reset state and readout of every neuron
        doReset();
        readAll();

        // Integrate and fire, all four spike together in timestep 4
        setAll(50, 0, 200);
        applyStimulus(0);
        readOne(0, 50, "itf_ts1");
        applyStimulus(0);
        readOne(1, 100, "itf_ts2");
        applyStimulus(0);
        readOne(2, 150, "itf_ts3");
        applyStimulus(0);
        checkOutput("itf_spikes", spikes, 4);
        checkOutput("itf_len", busyCycles, 8);
        readAll();
        readOne(3, 0, "itf_ts4");
        applyStimulus(0);
`ifdef LIF_SCHED_REFRACTORY_EN
        readOne(0, 0, "refr_ts5");
        applyStimulus(0);
        readOne(0, 50, "refr_ts6");
`else
        readOne(0, 50, "norefr_ts5");
`endif

        // Leak with beta=1
        doReset();
        setAll(100, 1, 255);
        applyStimulus(0);
        readOne(0, 100, "leak_ts1");
        applyStimulus(0);
        readOne(0, 150, "leak_ts2");
        applyStimulus(0);
        readOne(0, 175, "leak_ts3");
        checkOutput("leak_spikes", spikes, 0);

        // Saturation clamps to 255 and fires at threshold 255
        doReset();
        setAll(200, 0, 255);
        applyStimulus(0);
        readOne(0, 200, "sat_ts1");
        applyStimulus(0);
        checkOutput("sat_spikes", spikes, 4);
        readOne(0, 0, "sat_ts2");

        // Backpressure: five stalled cycles on the first spike
        doReset();
        setAll(50, 0, 200);
        applyStimulus(0);
        applyStimulus(0);
        applyStimulus(0);
        applyStimulus(2);
        checkOutput("bp_len", busyCycles, 13);
        readAll();

        // Reset during the RUN cycle of neuron 2
        doReset();
        setAll(50, 0, 200);
        cur_data = 8'd50;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        @(posedge clk);
        @(negedge clk);
        @(posedge clk);
        @(negedge clk);
        checkOutput("mid_cur_idx", int'(cur_idx), 2);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 6; k++) begin
            checkOutput("mid_no_done", int'(done), 0);
            checkOutput("mid_busy", int'(busy), 0);
            checkOutput("mid_valid", int'(spike_valid), 0);
            @(posedge clk);
            @(negedge clk);
        end
        for (int n = 0; n < N; n++) begin
            modelState[n] = 0;
            modelRefr[n]  = 1'b0;
        end
        readAll();

        // Randomized timesteps with random backpressure
        doReset();
        for (int t = 0; t < 20; t++) begin
            for (int n = 0; n < N; n++) curArr[n] = $urandom_range(0, 255);
            beta = 3'($urandom_range(0, 7));
            threshold = W'($urandom_range(0, 255));
            applyStimulus(1);
            readAll();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/lif_scheduler.md
# lif_scheduler

Time-multiplexed controller for a layer of leaky integrate-and-fire neurons. It holds N membrane states in a register file and drives one shared leak/integrate/fire datapath across them in round-robin order, one neuron per cycle, once per timestep. Spikes are emitted as indexed events on a valid/ready port with backpressure. It sits between the input current source (switches or an upstream layer) and the spike consumer or display logic in the top-level wrapper.

## Interface
Parameters:
- `N_NEURONS`, 4: neurons in the layer (2..16)
- `WIDTH`, 8: membrane, current and threshold width in bits

Ports:
- `clk` in 1: the single clock
- `rst` in 1: synchronous, active-high reset
- `start` in 1: begin one timestep; sampled only in IDLE
- `beta` in 3: leak shift; 0 means no leak
- `threshold` in WIDTH: fire when the updated state is >= threshold
- `cur_idx` out clog2(N): index of the neuron whose current is requested
- `cur_data` in WIDTH: current for `cur_idx`, sampled in the same cycle
- `spike_valid` out 1: a spike event is pending
- `spike_idx` out clog2(N): neuron that fired
- `spike_ready` in 1: the consumer accepts the event
- `busy` out 1: a timestep is in progress
- `done` out 1: one-cycle pulse when the timestep completes
- `mem_sel` in clog2(N): membrane readout select
- `mem_out` out WIDTH: registered membrane state of `mem_sel`

## Operation
- FSM states: IDLE, RUN, EMIT, DONE.
- **IDLE**: when `start`=1, clear the neuron index i to 0 and go to RUN.
- **RUN**: `cur_idx`=i.
  - Leak: `leak` = 0 if `beta`=0, else `state[i] >> beta`.
  - Integrate: `sum` = `state[i] - leak + cur_data`, computed in WIDTH+1 bits and clamped to 2^WIDTH-1.
  - If `sum >= threshold`: write 0 to `state[i]`, set `spike_valid`=1 and `spike_idx`=i, then go to EMIT.
  - Otherwise: write `sum` to `state[i]`. If i = N-1 go to DONE, else i++ and stay in RUN.
- **EMIT**: hold `spike_valid` and `spike_idx` stable until `spike_ready`=1. On the handshake, clear `spike_valid`. If i = N-1 go to DONE, else i++ and go to RUN. No neuron is updated while in EMIT.
- **DONE**: `done`=1 for one cycle, then go to IDLE.
- `start` outside IDLE is ignored, not queued.
- `beta`, `threshold` and `cur_data` are used live. The system must hold `beta` and `threshold` stable while `busy`=1.
- Neurons are always updated in index order 0..N-1, and each neuron is updated exactly once per timestep.

## Timing
- Reset: every `state` entry is 0, FSM is in IDLE, i=0. `cur_idx`, `spike_valid`, `spike_idx`, `busy`, `done` and `mem_out` are all 0.
- Reset asserted mid-timestep: the next edge forces the full reset state. A pending spike is dropped and no `done` pulse is produced.
- `busy`=1 in RUN and EMIT. `busy`=0 in IDLE and DONE.
- Timestep length: the first RUN cycle is the cycle after `start` is sampled. With no spikes, `busy` lasts N cycles and `done` follows in the next cycle.
- Each spike adds one EMIT cycle, plus one cycle for every cycle `spike_ready` stays low.
- `mem_out` updates one cycle after `mem_sel` changes. It reflects writes made on the previous edge.

## Configuration
- `LIF_SCHED_REFRACTORY_EN` defined:
  - Each neuron has a refractory flag. The flag is set when the neuron fires.
  - In that neuron's next timestep, RUN skips integration: `state` stays 0, no spike is possible, and the flag clears.
  - The RUN cycle for that neuron is still consumed, so timestep length is unchanged.
  - Reset clears all flags.
- Not defined: no refractory period; a neuron integrates in the timestep right after it fires.

## Test plan
With N=4, WIDTH=8:
1. **Reset**: assert `rst` for 2 cycles -> `busy`=`done`=`spike_valid`=0, and `mem_out`=0 for every `mem_sel`.
2. **Integrate and fire**: `cur_data`=50, `beta`=0, `threshold`=200, `spike_ready`=1, 4 timesteps -> states read 50, 100, 150 after timesteps 1-3. In timestep 4, spikes occur with `spike_idx` 0, 1, 2, 3 in order, and all states end at 0. With REFRACTORY_EN, timestep 5 leaves all states at 0 and timestep 6 gives 50.
3. **Leak**: `cur_data`=100, `beta`=1, `threshold`=255 -> state reads 100, 150, 175 after timesteps 1, 2, 3, with no spikes.
4. **Saturation**: `cur_data`=200, `beta`=0, `threshold`=255 -> state is 200 after timestep 1. Timestep 2 clamps to 255 and fires.
5. **Backpressure**: setup of test 2, with `spike_ready`=0 for 5 cycles at the first spike -> `spike_valid`=1 and `spike_idx`=0 held for those cycles, `cur_idx` stays at 0, `busy`=1. Neuron 1 is updated only after the handshake. `done` comes 5 cycles later than the unstalled case.
6. **Start and reset corner cases**: pulse `start` while `busy`=1 -> ignored, and exactly one `done` follows. Assert `rst` in the RUN cycle for neuron 2 -> no `done` pulse, and all states read 0.
